// File: rtl/core_writeback_arbiter.sv
// core_writeback_arbiter: merges fixed and round-robin stallable results onto registered RF write ports.
// Define WB_RD0_DROP_EN to consume rd=0 writes without occupying a port.
module core_writeback_arbiter #(
  parameter int N_PORTS = 2,
  parameter int N_SRC   = 2,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         fix_valid,
  input  logic [N_PORTS*RD_W-1:0]    fix_rd,
  input  logic [N_PORTS*DATA_W-1:0]  fix_data,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*RD_W-1:0]      src_rd,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  output logic [N_SRC-1:0]           src_stall,
  output logic [N_PORTS-1:0]         wr_valid,
  output logic [N_PORTS*RD_W-1:0]    wr_rd,
  output logic [N_PORTS*DATA_W-1:0]  wr_data
);
`ifdef WB_RD0_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  localparam int PW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  logic [PW-1:0]             rr_q, rr_d;
  logic [N_PORTS-1:0]        v_d;
  logic [N_PORTS*RD_W-1:0]   rd_d;
  logic [N_PORTS*DATA_W-1:0] data_d;
  always_comb begin
    rr_d      = rr_q;
    src_stall = '0;
    v_d       = '0;
    rd_d      = wr_rd;
    data_d    = wr_data;
    for (int p = 0; p < N_PORTS; p++)
      if (fix_valid[p] && !(DROP && fix_rd[p*RD_W +: RD_W] == '0)) begin
        v_d[p]                   = 1'b1;
        rd_d[p*RD_W +: RD_W]     = fix_rd[p*RD_W +: RD_W];
        data_d[p*DATA_W +: DATA_W] = fix_data[p*DATA_W +: DATA_W];
      end
    // v_d/rd_d double as the record of writes already granted this cycle
    for (int k = 0; k < N_SRC; k++) begin
      int   i;
      logic hit;
      logic done;
      i    = int'(rr_q) + k;
      i    = i >= N_SRC ? i - N_SRC : i;
      hit  = 1'b0;
      done = 1'b0;
      for (int p = 0; p < N_PORTS; p++)
        hit = hit | (v_d[p] && rd_d[p*RD_W +: RD_W] == src_rd[i*RD_W +: RD_W]);
      if (src_valid[i] && !(DROP && src_rd[i*RD_W +: RD_W] == '0)) begin
        for (int p = 0; p < N_PORTS; p++)
          if (!hit && !done && !v_d[p]) begin
            v_d[p]                     = 1'b1;
            rd_d[p*RD_W +: RD_W]       = src_rd[i*RD_W +: RD_W];
            data_d[p*DATA_W +: DATA_W] = src_data[i*DATA_W +: DATA_W];
            done                       = 1'b1;
            rr_d                       = PW'(i + 1 >= N_SRC ? 0 : i + 1);
          end
        src_stall[i] = !done;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_valid <= '0;
      wr_rd    <= '0;
      wr_data  <= '0;
      rr_q     <= '0;
    end else begin
      wr_valid <= v_d;
      wr_rd    <= rd_d;
      wr_data  <= data_d;
      rr_q     <= rr_d;
    end
endmodule

// File: tb/tb_core_writeback_arbiter.sv
// tb_core_writeback_arbiter: directed vector table plus randomized run against a queue-based reference model.
module tb_core_writeback_arbiter;
  localparam int NP = 2, NS = 2, DW = 32, RW = 4;
`ifdef WB_RD0_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    fix_valid;
  logic [NP*RW-1:0] fix_rd;
  logic [NP*DW-1:0] fix_data;
  logic [NS-1:0]    src_valid;
  logic [NS*RW-1:0] src_rd;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_stall;
  logic [NP-1:0]    wr_valid;
  logic [NP*RW-1:0] wr_rd;
  logic [NP*DW-1:0] wr_data;
  int nchecks = 0, nerr = 0;
  logic [NP-1:0]    m_v = '0, n_v;
  logic [NP*RW-1:0] m_rd = '0, n_rd;
  logic [NP*DW-1:0] m_data = '0, n_data;
  logic [NS-1:0]    m_stall;
  int m_rr = 0, n_rr;
  typedef struct {
    logic       rst;
    logic [1:0] fv;
    logic [7:0] frd;
    logic [1:0] sv;
    logic [7:0] srd;
    logic [1:0] stall;
    logic [1:0] wv;
    logic [7:0] wrd;
  } vec_t;
  vec_t tbl[12];
  core_writeback_arbiter #(.N_PORTS(NP), .N_SRC(NS), .DATA_W(DW), .RD_W(RW)) dut (
    .clk(clk), .rst(rst),
    .fix_valid(fix_valid), .fix_rd(fix_rd), .fix_data(fix_data),
    .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data),
    .src_stall(src_stall), .wr_valid(wr_valid), .wr_rd(wr_rd), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Reference: fixed claims first, remaining ports form a free list, sources visited in rotated order
  task automatic model_eval();
    int free[$];
    logic [RW-1:0] used[$];
    m_stall = '0;
    n_v     = '0;
    n_rd    = m_rd;
    n_data  = m_data;
    n_rr    = m_rr;
    for (int p = 0; p < NP; p++) begin
      logic [RW-1:0] r = fix_rd[p*RW +: RW];
      if (fix_valid[p] && !(DROP && r == 0)) begin
        n_v[p] = 1'b1;
        n_rd[p*RW +: RW] = r;
        n_data[p*DW +: DW] = fix_data[p*DW +: DW];
        used.push_back(r);
      end else free.push_back(p);
    end
    for (int k = 0; k < NS; k++) begin
      int i = (m_rr + k) % NS;
      logic [RW-1:0] r = src_rd[i*RW +: RW];
      bit clash = 1'b0;
      if (!src_valid[i] || (DROP && r == 0)) continue;
      foreach (used[j]) if (used[j] == r) clash = 1'b1;
      if (clash || free.size() == 0) m_stall[i] = 1'b1;
      else begin
        int p = free.pop_front();
        n_v[p] = 1'b1;
        n_rd[p*RW +: RW] = r;
        n_data[p*DW +: DW] = src_data[i*DW +: DW];
        used.push_back(r);
        n_rr = (i + 1) % NS;
      end
    end
  endtask
  task automatic model_commit();
    if (rst) begin
      m_v = '0; m_rd = '0; m_data = '0; m_rr = 0;
    end else begin
      m_v = n_v; m_rd = n_rd; m_data = n_data; m_rr = n_rr;
    end
  endtask
  initial begin
    rst = 1'b1; fix_valid = '0; fix_rd = '0; fix_data = '0;
    src_valid = '0; src_rd = '0; src_data = '0;
    tbl[0]  = '{1'b1, 2'b11, 8'h21, 2'b11, 8'h43, 2'b11, 2'b00, 8'h00};
    tbl[1]  = '{1'b1, 2'b11, 8'h21, 2'b11, 8'h43, 2'b11, 2'b00, 8'h00};
    tbl[2]  = '{1'b0, 2'b11, 8'h53, 2'b11, 8'h76, 2'b11, 2'b11, 8'h53};
    tbl[3]  = '{1'b0, 2'b01, 8'h01, 2'b11, 8'h32, 2'b10, 2'b11, 8'h21};
    tbl[4]  = '{1'b0, 2'b01, 8'h01, 2'b11, 8'h32, 2'b01, 2'b11, 8'h31};
    tbl[5]  = '{1'b0, 2'b01, 8'h01, 2'b11, 8'h32, 2'b10, 2'b11, 8'h21};
    tbl[6]  = '{1'b0, 2'b01, 8'h01, 2'b11, 8'h32, 2'b01, 2'b11, 8'h31};
    tbl[7]  = '{1'b0, 2'b01, 8'h07, 2'b10, 8'h70, 2'b10, 2'b01, 8'h37};
    tbl[8]  = '{1'b0, 2'b11, 8'h21, 2'b01, 8'h50, DROP ? 2'b00 : 2'b01, 2'b11, 8'h21};
    tbl[9]  = '{1'b0, 2'b00, 8'h11, 2'b10, 8'h90, 2'b00, 2'b01, 8'h29};
    tbl[10] = '{1'b1, 2'b00, 8'h11, 2'b10, 8'h90, 2'b00, 2'b00, 8'h00};
    tbl[11] = '{1'b0, 2'b10, 8'h41, 2'b11, 8'h54, 2'b01, 2'b11, 8'h45};
    for (int n = 0; n < 12; n++) begin
      rst = tbl[n].rst; fix_valid = tbl[n].fv; fix_rd = tbl[n].frd;
      src_valid = tbl[n].sv; src_rd = tbl[n].srd;
      fix_data = {32'hB, 32'hA}; src_data = {32'hD, 32'hC};
      #1;
      model_eval();
      chk($sformatf("vec%0d stall", n), 64'(src_stall), 64'(tbl[n].stall));
      @(posedge clk);
      model_commit();
      #1;
      chk($sformatf("vec%0d wr_valid", n), 64'(wr_valid), 64'(tbl[n].wv));
      chk($sformatf("vec%0d wr_rd", n), 64'(wr_rd), 64'(tbl[n].wrd));
    end
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 31) == 0;
      fix_valid = 2'($urandom_range(0, 3));
      src_valid = 2'($urandom_range(0, 3));
      fix_rd = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      src_rd = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      fix_data = {$urandom, $urandom};
      src_data = {$urandom, $urandom};
      #1;
      model_eval();
      chk($sformatf("rnd%0d stall", n), 64'(src_stall), 64'(m_stall));
      @(posedge clk);
      model_commit();
      #1;
      chk($sformatf("rnd%0d wr_valid", n), 64'(wr_valid), 64'(m_v));
      chk($sformatf("rnd%0d wr_rd", n), 64'(wr_rd), 64'(m_rd));
      chk($sformatf("rnd%0d wr_data", n), wr_data, m_data);
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
